mdu_issue: RTL and testbench
============================

Name: mdu_issue

Overview:
- D→E issue stage for the multiply/divide unit: captures the decoded MDU opcode and forwarded operands, and presents them to the MDU for exactly one E-stage cycle.
- Tracks the MDU's busy window with its own countdown and raises a D-stage stall for any MDU instruction (including MFHI/MFLO/MTHI/MTLO) while that window is open.
- Sits between the decode/forwarding logic and the MDU; the hazard unit ORs stall_d into the global stall.

Parameters:
- MUL_LAT, 5, busy cycles charged for MULT/MULTU (and MADD-class when enabled).
- DIV_LAT, 10, busy cycles charged for DIV/DIVU.
- CNT_W, 4, busy counter width; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
- d_mdu_op  in  4  decoded MDU op in D (0 = none; 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9–12 see feature).
- d_a  in  32  forwarded rs value.
- d_b  in  32  forwarded rt value.
- ext_stall  in  1  stall from other hazard sources; D must not advance.
- e_flush  in  1  bubble the E stage at this edge.
- stall_d  out  1  MDU structural stall request (combinational).
- mdu_start  out  1  E stage holds a valid MDU op (registered).
- mdu_op  out  4  opcode to MDU; 0 when mdu_start=0.
- mdu_a  out  32  operand A to MDU; 0 when mdu_start=0.
- mdu_b  out  32  operand B to MDU; 0 when mdu_start=0.
- busy  out  1  busy counter nonzero.
- ill_op  out  1  one-cycle pulse: unsupported opcode was dropped at issue.

Behaviour:
- Reset (reset=0 at edge): mdu_start, mdu_op, mdu_a, mdu_b, busy counter, ill_op all 0; FSM to IDLE. Reset mid-operation abandons the window immediately, with no residual stall.
- Op classes: MUL = {1,2}; DIV = {3,4}; MOVE = {5,6,7,8}; NONE = 0.
- stall_d = (d_mdu_op != 0) && (cnt != 0). Combinational, with no dependence on ext_stall.
- Issue condition at edge: d_mdu_op valid class && !stall_d && !ext_stall && !e_flush. On issue: mdu_start<=1, mdu_op/mdu_a/mdu_b <= D values. Otherwise all four are 0 (bubble).
- mdu_start is high for exactly one cycle per issued instruction, so back-to-back issue gives consecutive pulses.
- Counter load on issue: MUL → MUL_LAT, DIV → DIV_LAT, MOVE → unchanged (cnt is already 0).
- Counter otherwise decrements by 1 per cycle while nonzero and saturates at 0. busy = (cnt != 0).
- FSM states:
  - IDLE (cnt=0).
  - MUL_BUSY.
  - DIV_BUSY.
  - IDLE→MUL_BUSY/DIV_BUSY on issue of the respective class.
  - *_BUSY→IDLE on the edge where cnt goes 1→0.
  - There is no *_BUSY→*_BUSY transition, because issue is blocked while busy.
- Timing: MULT issued at edge 0 → cnt=5 after edge 0, 0 after edge 5. A dependent MDU op waiting in D issues at edge 6; DIV equivalently at edge 11.
- Simultaneous events:
  - e_flush with a would-be issue → flush wins: no start, no counter load.
  - ext_stall with a would-be issue → no issue; the counter still decrements.
  - e_flush does not cancel an already-started busy window, because the MDU has committed.
- B==0 on DIV still charges DIV_LAT.
- Unsupported opcode (13–15, or 9–12 without the feature): not issued, no stall, counter untouched. ill_op=1 for the cycle following the edge where it would have issued.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU are MUL class (MUL_LAT, issued as normal, FSM→MUL_BUSY).
- Undefined: 9–12 are unsupported (dropped, ill_op pulse). The port list is unchanged.

Decomposition:
- Package mdu_pkg: opcode localparams (MDU_NONE..MDU_MSUBU), class-decode function, default MUL_LAT/DIV_LAT, FSM state encoding.
- One sub-module: mdu_busy_cnt (load/decrement/saturate counter with busy output).
- Issue register and FSM stay in mdu_issue.

Test Plan:
- Reset: hold reset=0 for 2 cycles with d_mdu_op=1 → mdu_start=0, busy=0, stall_d=0 throughout; on release, MULT issues at the first edge.
- MULT a=3 b=5, MFLO in next D slot → stall_d high 5 cycles; MFLO mdu_start at edge 6; mdu_op=6, mdu_a=0 on MULT+1 cycle.
- DIVU a=100 b=0 then MTHI a=0xDEADBEEF → busy 10 cycles; MTHI issues at edge 11 with mdu_a=0xDEADBEEF.
- Flush vs issue: DIV in D with e_flush=1 at the issue edge → no start, busy stays 0; the same DIV re-presented next cycle issues normally.
- Reset mid-DIV at cnt=4 → busy=0 after that edge, stall_d=0 for a waiting MFHI, which issues on the edge after reset release.
- Op 9: with MDU_MADD_EN → start pulse + 5-cycle busy; without → ill_op=1 for one cycle, mdu_start=0, busy=0.

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Opcodes, op-class decode, default latencies and FSM encoding
//               for the MDU issue stage. MDU_MADD_EN enables ops 9-12.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;
    localparam logic [3:0] MDU_MADDU = 4'd10;
    localparam logic [3:0] MDU_MSUB  = 4'd11;
    localparam logic [3:0] MDU_MSUBU = 4'd12;

    typedef logic [2:0] mdu_cls_t;
    localparam mdu_cls_t c_CLS_NONE = 3'd0;
    localparam mdu_cls_t c_CLS_MUL  = 3'd1;
    localparam mdu_cls_t c_CLS_DIV  = 3'd2;
    localparam mdu_cls_t c_CLS_MOVE = 3'd3;
    localparam mdu_cls_t c_CLS_ILL  = 3'd4;

    typedef logic [1:0] mdu_state_t;
    localparam mdu_state_t c_ST_IDLE     = 2'd0;
    localparam mdu_state_t c_ST_MUL_BUSY = 2'd1;
    localparam mdu_state_t c_ST_DIV_BUSY = 2'd2;

    function automatic mdu_cls_t mdu_class(input logic [3:0] op);
        mdu_cls_t cls;
        case (op)
            MDU_NONE:                               cls = c_CLS_NONE;
            MDU_MULT, MDU_MULTU:                    cls = c_CLS_MUL;
            MDU_DIV, MDU_DIVU:                      cls = c_CLS_DIV;
            MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO: cls = c_CLS_MOVE;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: cls = c_CLS_MUL;
`endif
            default:                                cls = c_CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_busy_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mdu_busy_cnt
// Description : MDU busy-window countdown: load, decrement, saturate at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_busy_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign busy = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/mdu_issue.sv
`default_nettype none
// ============================================================================
// Module      : mdu_issue
// Description : D->E issue stage for the multiply/divide unit with busy-window
//               stall. Define MDU_MADD_EN to issue MADD/MADDU/MSUB/MSUBU.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_issue
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  d_mdu_op,
    input  logic [31:0] d_a,
    input  logic [31:0] d_b,
    input  logic        ext_stall,
    input  logic        e_flush,
    output logic        stall_d,
    output logic        mdu_start,
    output logic [3:0]  mdu_op,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    output logic        busy,
    output logic        ill_op
);

    mdu_cls_t         w_cls;
    logic             w_valid;
    logic             w_issue;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_cnt;
    logic             w_busy;
    mdu_state_t       r_state;
    mdu_state_t       w_state_nxt;

    logic             r_start;
    logic [3:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic             r_ill;

    assign w_cls   = mdu_class(d_mdu_op);
    assign w_valid = (w_cls == c_CLS_MUL) || (w_cls == c_CLS_DIV) || (w_cls == c_CLS_MOVE);

    // Unsupported opcodes never stall; they are dropped with an ill_op pulse.
    assign stall_d = w_valid && w_busy;
    assign w_issue = w_valid && !w_busy && !ext_stall && !e_flush;

    assign w_load     = w_issue && ((w_cls == c_CLS_MUL) || (w_cls == c_CLS_DIV));
    assign w_load_val = (w_cls == c_CLS_DIV) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

    mdu_busy_cnt #(
        .CNT_W (CNT_W)
    ) u_busy_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .cnt      (w_cnt),
        .busy     (w_busy)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_start <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_ill   <= 1'b0;
        end else begin
            r_start <= w_issue;
            r_op    <= w_issue ? d_mdu_op : 4'd0;
            r_a     <= w_issue ? d_a : 32'd0;
            r_b     <= w_issue ? d_b : 32'd0;
            r_ill   <= (w_cls == c_CLS_ILL) && !ext_stall && !e_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_load && (w_cls == c_CLS_DIV)) begin
                    w_state_nxt = c_ST_DIV_BUSY;
                end else if (w_load) begin
                    w_state_nxt = c_ST_MUL_BUSY;
                end
            end
            c_ST_MUL_BUSY, c_ST_DIV_BUSY: begin
                if (w_cnt == CNT_W'(1)) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign mdu_start = r_start;
    assign mdu_op    = r_op;
    assign mdu_a     = r_a;
    assign mdu_b     = r_b;
    assign busy      = w_busy;
    assign ill_op    = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_issue
// Description : Self-checking bench for mdu_issue against a cycle-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_issue;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  d_mdu_op;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic        ext_stall;
    logic        e_flush;
    logic        stall_d;
    logic        mdu_start;
    logic [3:0]  mdu_op;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic        busy;
    logic        ill_op;

    int          n_err = 0;
    int          n_chk = 0;

    int          m_cnt = 0;
    logic        exp_start = 1'b0;
    logic [3:0]  exp_op = '0;
    logic [31:0] exp_a = '0;
    logic [31:0] exp_b = '0;
    logic        exp_ill = 1'b0;
    logic        last_stall;
    int          n_stall;
    int          n_start;

    mdu_issue #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d_mdu_op  (d_mdu_op),
        .d_a       (d_a),
        .d_b       (d_b),
        .ext_stall (ext_stall),
        .e_flush   (e_flush),
        .stall_d   (stall_d),
        .mdu_start (mdu_start),
        .mdu_op    (mdu_op),
        .mdu_a     (mdu_a),
        .mdu_b     (mdu_b),
        .busy      (busy),
        .ill_op    (ill_op)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // 0 none, 1 multiply, 2 divide, 3 HI/LO move, 4 unsupported
    function automatic int op_kind(input int op);
        if (op == 0) return 0;
        if (op <= 2) return 1;
        if (op <= 4) return 2;
        if (op <= 8) return 3;
`ifdef MDU_MADD_EN
        if (op <= 12) return 1;
`endif
        return 4;
    endfunction

    task automatic cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic xs, input logic fl, input logic rn);
        int k;
        bit iss;
        d_mdu_op  = op;
        d_a       = a;
        d_b       = b;
        ext_stall = xs;
        e_flush   = fl;
        reset     = rn;
        #1;
        k = op_kind(int'(op));
        last_stall = stall_d;
        check_eq("stall_d", {31'd0, stall_d}, {31'd0, (k >= 1 && k <= 3 && m_cnt != 0)});
        @(posedge clk);
        if (!rn) begin
            exp_start = 1'b0; exp_op = '0; exp_a = '0; exp_b = '0; exp_ill = 1'b0;
            m_cnt = 0;
        end else begin
            iss = (k >= 1 && k <= 3) && (m_cnt == 0) && !xs && !fl;
            exp_start = iss;
            exp_op    = iss ? op : 4'd0;
            exp_a     = iss ? a : 32'd0;
            exp_b     = iss ? b : 32'd0;
            exp_ill   = (k == 4) && !xs && !fl;
            if (iss && k == 1)      m_cnt = MUL_LAT;
            else if (iss && k == 2) m_cnt = DIV_LAT;
            else if (m_cnt > 0)     m_cnt = m_cnt - 1;
        end
        #1;
        check_eq("mdu_start", {31'd0, mdu_start}, {31'd0, exp_start});
        check_eq("mdu_op",    {28'd0, mdu_op},    {28'd0, exp_op});
        check_eq("mdu_a",     mdu_a,              exp_a);
        check_eq("mdu_b",     mdu_b,              exp_b);
        check_eq("busy",      {31'd0, busy},      {31'd0, (m_cnt != 0)});
        check_eq("ill_op",    {31'd0, ill_op},    {31'd0, exp_ill});
        if (mdu_start) n_start++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        reset = 1'b0; d_mdu_op = '0; d_a = '0; d_b = '0; ext_stall = 1'b0; e_flush = 1'b0;

        // reset held with MULT in D, then MULT issues at first edge
        cycle(4'd1, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
        cycle(4'd1, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
        cycle(4'd1, 32'd3, 32'd5, 1'b0, 1'b0, 1'b1);
        n_stall = 0; n_start = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(4'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            if (last_stall) n_stall++;
            else break;
        end
        check_eq("mul_stall_len", n_stall, 5);
        check_eq("mflo_issued", n_start, 1);
        idle(2);

        // DIVU by zero charges the full divide latency
        cycle(4'd4, 32'd100, 32'd0, 1'b0, 1'b0, 1'b1);
        n_stall = 0;
        for (int i = 0; i < 11; i++) begin
            cycle(4'd7, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b1);
            if (last_stall) n_stall++;
            else break;
        end
        check_eq("div_stall_len", n_stall, 10);
        check_eq("mthi_a", mdu_a, 32'hDEADBEEF);
        idle(2);

        // flush beats issue, then the same DIV issues
        cycle(4'd3, 32'd7, 32'd2, 1'b0, 1'b1, 1'b1);
        cycle(4'd3, 32'd7, 32'd2, 1'b0, 1'b0, 1'b1);
        idle(11);

        // reset mid-divide at cnt=4 clears the window
        cycle(4'd3, 32'd9, 32'd3, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(4'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        cycle(4'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle(4'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // op 9: MADD when enabled, dropped otherwise
        cycle(4'd9, 32'd11, 32'd12, 1'b0, 1'b0, 1'b1);
        idle(7);

        // ext_stall blocks issue while the counter keeps draining
        cycle(4'd1, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1);
        cycle(4'd2, 32'd1, 32'd1, 1'b1, 1'b0, 1'b1);
        idle(6);

        // randomized traffic, holding ops in D to mimic stalled instructions
        r_op = 4'd0; r_a = '0; r_b = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0 || !stall_d) begin
                r_op = 4'($urandom_range(0, 15));
                r_a  = $urandom;
                r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            end
            cycle(r_op, r_a, r_b,
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 59) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
